// File: rtl/fsm_vend_change.sv
// Vending controller: collects 1.0/0.5 coins, vends at PRICE halves, pays change, refunds on cancel.
// Ports: sys_clk, sys_rst_n (async low); pi_money_one/half, pi_cancel in; po_cola, po_change_one/half,
//   po_busy, po_credit out; po_sales_cnt only when SALES_CNT_EN is defined.
module fsm_vend_change #(
  parameter int PRICE  = 5,
  parameter int CRED_W = $clog2(PRICE + 3)
`ifdef SALES_CNT_EN
  ,
  parameter int SALES_W = 16
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pi_money_one,
  input  logic              pi_money_half,
  input  logic              pi_cancel,
  output logic              po_cola,
  output logic              po_change_one,
  output logic              po_change_half,
  output logic              po_busy,
  output logic [CRED_W-1:0] po_credit
`ifdef SALES_CNT_EN
  ,
  output logic [SALES_W-1:0] po_sales_cnt
`endif
);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_VEND,
    S_PAYOUT
  } state_e;

  localparam logic [CRED_W-1:0] PRICE_C = CRED_W'(PRICE);
  localparam logic [CRED_W-1:0] ONE_C   = CRED_W'(2);
  localparam logic [CRED_W-1:0] HALF_C  = CRED_W'(1);

  state_e            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W-1:0] change_q, change_d;
  logic [CRED_W-1:0] add, nxt;
  logic              cola_q, one_q, half_q, busy_q;

  assign add = CRED_W'({pi_money_one, pi_money_half});
  assign nxt = credit_q + add;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    unique case (state_q)
      S_COLLECT: begin
        if (pi_cancel) begin
          // Cancel beats a vend; same-cycle coins join the refund.
          if (nxt != '0) begin
            change_d = nxt;
            credit_d = '0;
            state_d  = S_PAYOUT;
          end
        end else if (nxt >= PRICE_C) begin
          change_d = nxt - PRICE_C;
          credit_d = '0;
          state_d  = S_VEND;
        end else begin
          credit_d = nxt;
        end
      end
      S_VEND: begin
        state_d = (change_q != '0) ? S_PAYOUT : S_COLLECT;
      end
      S_PAYOUT: begin
        if (change_q >= ONE_C) begin
          change_d = change_q - ONE_C;
        end else if (change_q == HALF_C) begin
          change_d = '0;
        end else begin
          change_d = '0;
        end
        if (change_d == '0) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d  = S_COLLECT;
        credit_d = '0;
        change_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_COLLECT;
      credit_q <= '0;
      change_q <= '0;
      cola_q   <= 1'b0;
      one_q    <= 1'b0;
      half_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      // Outputs decode the upcoming state so they line up with it.
      cola_q   <= (state_d == S_VEND);
      one_q    <= (state_d == S_PAYOUT) && (change_d >= ONE_C);
      half_q   <= (state_d == S_PAYOUT) && (change_d == HALF_C);
      busy_q   <= (state_d != S_COLLECT);
    end
  end

  assign po_cola        = cola_q;
  assign po_change_one  = one_q;
  assign po_change_half = half_q;
  assign po_busy        = busy_q;
  assign po_credit      = credit_q;

`ifdef SALES_CNT_EN
  logic [SALES_W-1:0] sales_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sales_q <= '0;
    end else if ((state_q == S_VEND) && (sales_q != '1)) begin
      sales_q <= sales_q + 1'b1;
    end
  end

  assign po_sales_cnt = sales_q;
`endif

endmodule

// File: tb/tb_fsm_vend_change.sv
// Scoreboard bench for fsm_vend_change: a queue-based purchase model feeds
// per-cycle expectations to a negedge monitor.
module tb_fsm_vend_change;

  localparam int PRICE = 5;
  localparam int CW    = $clog2(PRICE + 3);

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          one       = 1'b0;
  logic          half      = 1'b0;
  logic          cancel    = 1'b0;
  logic          po_cola, po_c1, po_c05, po_busy;
  logic [CW-1:0] po_credit;
`ifdef SALES_CNT_EN
  logic [15:0]   po_sales;
`endif

  fsm_vend_change #(.PRICE(PRICE)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .pi_money_one   (one),
    .pi_money_half  (half),
    .pi_cancel      (cancel),
    .po_cola        (po_cola),
    .po_change_one  (po_c1),
    .po_change_half (po_c05),
    .po_busy        (po_busy),
    .po_credit      (po_credit)
`ifdef SALES_CNT_EN
    ,
    .po_sales_cnt   (po_sales)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          cola;
    logic          c1;
    logic          c05;
    logic          busy;
    logic [CW-1:0] credit;
  } obs_t;

  obs_t sb[$];
  obs_t sched[$];
  int   m_credit = 0;
  int   checks   = 0;
  int   errors   = 0;

  function automatic obs_t mk(input logic c, input logic o,
                              input logic h);
    obs_t e;
    e      = '0;
    e.cola = c;
    e.c1   = o;
    e.c05  = h;
    e.busy = 1'b1;
    return e;
  endfunction

  // Greedy payout: 1.0 coins first, a final 0.5 if odd.
  function automatic void pay(input int amt);
    int a;
    a = amt;
    while (a >= 2) begin
      sched.push_back(mk(1'b0, 1'b1, 1'b0));
      a -= 2;
    end
    if (a == 1) sched.push_back(mk(1'b0, 1'b0, 1'b1));
  endfunction

  task automatic step(input logic o, input logic h, input logic c);
    obs_t e;
    int   tot;
    @(posedge sys_clk);
    #1;
    if (sched.size() > 0) begin
      e = sched.pop_front();
    end else begin
      e        = '0;
      e.credit = CW'(m_credit);
    end
    sb.push_back(e);
    if (!e.busy) begin
      tot = m_credit + 2 * int'(o) + int'(h);
      if (c) begin
        if (tot > 0) begin
          pay(tot);
          m_credit = 0;
        end
      end else if (tot >= PRICE) begin
        sched.push_back(mk(1'b1, 1'b0, 1'b0));
        pay(tot - PRICE);
        m_credit = 0;
      end else begin
        m_credit = tot;
      end
    end
    one    = o;
    half   = h;
    cancel = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    obs_t g;
    g = {po_cola, po_c1, po_c05, po_busy, po_credit};
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected 0", nm, g);
    end
  endtask

  always @(negedge sys_clk) begin
    obs_t e, g;
    if (sys_rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      g = {po_cola, po_c1, po_c05, po_busy, po_credit};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got cola=%b c1=%b c05=%b busy=%b cr=%0d expected cola=%b c1=%b c05=%b busy=%b cr=%0d",
                 $time, g.cola, g.c1, g.c05, g.busy, g.credit,
                 e.cola, e.c1, e.c05, e.busy, e.credit);
      end
      checks++;
      if ($countones({po_cola, po_c1, po_c05}) > 1) begin
        errors++;
        $display("FAIL onehot @%0t: got %b expected at most one",
                 $time, {po_cola, po_c1, po_c05});
      end
    end
  end

  initial begin
    #3;
    chk_zero("reset_state");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    idle(2);
    // Five halves, one per cycle.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    idle(3);
    // Three ones: change of one half.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(4);
    // One, one, then one+half together: change of one 1.0.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(4);
    // One, half, cancel: refund 1.0 then 0.5.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(4);
    // Cancel with zero credit is ignored; cancel with coin refunds it.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    idle(4);
    // Coins and cancel while busy are dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(3);

    // Reset mid-payout.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    checks++;
    if (po_c1 !== 1'b1 || po_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_payout: got c1=%b busy=%b expected 1 1",
               po_c1, po_busy);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    sched.delete();
    m_credit = 0;
    repeat (2) @(posedge sys_clk);
    #2;
    chk_zero("in_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0));
    end
    idle(6);

    repeat (3) @(posedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
